// File: rtl/block_stream_scheduler_pkg.sv
// Shared types and constants for the block stream scheduler and its arbiter.
package block_stream_scheduler_pkg;

  localparam int unsigned BLOCK_BYTES = 16;
  localparam int unsigned SER_DRAIN   = 2;
  localparam int unsigned BLOCK_W     = 128;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DRAIN
  } sched_state_t;

endpackage

// File: rtl/block_stream_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: lowest requesting index at or above the pointer, wrapping.
module rr_arbiter
  import block_stream_scheduler_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned IDW     = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDW-1:0]     grant_idx,
  output logic               any
);

  logic [NUM_REQ-1:0] hi_mask;
  logic [NUM_REQ-1:0] masked;
  logic [NUM_REQ-1:0] pick;
  logic               found;

  always_comb begin
    hi_mask   = '0;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      hi_mask[i] = (IDW'(i) >= ptr);
    end
    masked = req & hi_mask;
    // Nothing at or above the pointer: wrap and take the lowest requester overall.
    pick = (|masked) ? masked : req;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!found && pick[i]) begin
        found     = 1'b1;
        grant[i]  = 1'b1;
        grant_idx = IDW'(i);
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/block_stream_scheduler.sv
// Round-robin owner of the 128-bit-to-byte serializer: grants a block source, paces byte
// requests against a valid/ready sink and releases the serializer after a drain interval.
module block_stream_scheduler #(
  parameter int unsigned NUM_REQ      = 2,
  parameter int unsigned BLOCK_BYTES  = block_stream_scheduler_pkg::BLOCK_BYTES,
  parameter int unsigned DRAIN_CYCLES = block_stream_scheduler_pkg::SER_DRAIN
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*128-1:0]     req_block,
  output logic [NUM_REQ-1:0]         req_ack,
  output logic                       ser_start,
  output logic [127:0]               ser_block,
  output logic                       ser_request,
  input  logic [7:0]                 ser_byte,
  input  logic                       ser_valid,
  output logic [7:0]                 tx_data,
  output logic                       tx_valid,
  input  logic                       tx_ready,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       block_done
);
  import block_stream_scheduler_pkg::*;

  localparam int unsigned IDW = $clog2(NUM_REQ);
  localparam int unsigned DCW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [4:0]  CNT_LAST = 5'(BLOCK_BYTES);

  sched_state_t         state_q, state_d;
  logic [IDW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]       grant_id_q, grant_id_d;
  logic [BLOCK_W-1:0]   ser_block_q, ser_block_d;
  logic [NUM_REQ-1:0]   req_ack_q, req_ack_d;
  logic [7:0]           tx_data_q, tx_data_d;
  logic                 tx_valid_q, tx_valid_d;
  logic                 busy_q, busy_d;
  logic [4:0]           cnt_q, cnt_d;
  logic [DCW-1:0]       drain_cnt_q, drain_cnt_d;

  logic [NUM_REQ-1:0]   arb_grant;
  logic [IDW-1:0]       arb_idx;
  logic                 arb_any;
  logic [BLOCK_W-1:0]   blk_sel;
  logic [IDW-1:0]       next_ptr;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_arb (
    .req       (req_valid),
    .ptr       (rr_ptr_q),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .any       (arb_any)
  );

  assign next_ptr = (grant_id_q == IDW'(NUM_REQ - 1)) ? '0 : grant_id_q + IDW'(1);

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_id_d  = grant_id_q;
    ser_block_d = ser_block_q;
    req_ack_d   = '0;
    tx_data_d   = tx_data_q;
    tx_valid_d  = tx_valid_q;
    busy_d      = busy_q;
    cnt_d       = cnt_q;
    drain_cnt_d = drain_cnt_q;
    ser_start   = 1'b0;
    ser_request = 1'b0;
    block_done  = 1'b0;
    blk_sel     = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (arb_grant[i]) blk_sel = req_block[i*BLOCK_W +: BLOCK_W];
    end

    unique case (state_q)
      S_IDLE: begin
        if (arb_any) begin
          ser_block_d = blk_sel;
          req_ack_d   = arb_grant;
          grant_id_d  = arb_idx;
          busy_d      = 1'b1;
          cnt_d       = '0;
          state_d     = S_START;
        end
      end
      S_START: begin
        ser_start = 1'b1;
        state_d   = S_REQ;
      end
      S_REQ: begin
        if (!tx_valid_q) begin
          ser_request = 1'b1;
          state_d     = S_WAIT;
        end
      end
      S_WAIT: begin
        // ser_valid is only honoured here; strays in other states are dropped.
        if (ser_valid) begin
          tx_data_d  = ser_byte;
          tx_valid_d = 1'b1;
          if (cnt_q != CNT_LAST) cnt_d = cnt_q + 5'd1;
          state_d    = S_HOLD;
        end
      end
      S_HOLD: begin
        if (tx_ready) begin
          tx_valid_d = 1'b0;
          if (cnt_q == CNT_LAST) begin
            block_done  = 1'b1;
            drain_cnt_d = '0;
            if (DRAIN_CYCLES == 0) begin
              busy_d   = 1'b0;
              rr_ptr_d = next_ptr;
              state_d  = S_IDLE;
            end else begin
              state_d  = S_DRAIN;
            end
          end else begin
            state_d = S_REQ;
          end
        end
      end
      S_DRAIN: begin
        if (drain_cnt_q == DCW'(DRAIN_CYCLES - 1)) begin
          busy_d   = 1'b0;
          rr_ptr_d = next_ptr;
          state_d  = S_IDLE;
        end else begin
          drain_cnt_d = drain_cnt_q + DCW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= '0;
      grant_id_q  <= '0;
      ser_block_q <= '0;
      req_ack_q   <= '0;
      tx_data_q   <= '0;
      tx_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
      cnt_q       <= '0;
      drain_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_id_q  <= grant_id_d;
      ser_block_q <= ser_block_d;
      req_ack_q   <= req_ack_d;
      tx_data_q   <= tx_data_d;
      tx_valid_q  <= tx_valid_d;
      busy_q      <= busy_d;
      cnt_q       <= cnt_d;
      drain_cnt_q <= drain_cnt_d;
    end
  end

  assign req_ack   = req_ack_q;
  assign ser_block = ser_block_q;
  assign tx_data   = tx_data_q;
  assign tx_valid  = tx_valid_q;
  assign busy      = busy_q;
  assign grant_id  = grant_id_q;

  // A request must always be answered on the very next cycle.
  property p_ser_valid_follows;
    @(posedge clk_in) disable iff (rst_in) ser_request |=> ser_valid;
  endproperty
  a_ser_valid_follows: assert property (p_ser_valid_follows);

endmodule
